// File: rtl/obi_wb_bus_arbiter_if.sv
// Signal bundle between a core's OBI fetch/data ports, the arbiter and the
// Wishbone bus. The arbiter uses the slave view; the core/bus side uses master.
interface obi_wb_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                      instr_req_i;
    logic [ADDR_WIDTH-1:0]     instr_addr_i;
    logic                      instr_gnt_o;
    logic                      instr_rvalid_o;
    logic [DATA_WIDTH-1:0]     instr_rdata_o;
    logic                      data_req_i;
    logic                      data_we_i;
    logic [DATA_WIDTH/8-1:0]   data_be_i;
    logic [ADDR_WIDTH-1:0]     data_addr_i;
    logic [DATA_WIDTH-1:0]     data_wdata_i;
    logic                      data_gnt_o;
    logic                      data_rvalid_o;
    logic [DATA_WIDTH-1:0]     data_rdata_o;
    logic                      data_err_o;
    logic                      wb_cyc_o;
    logic                      wb_stb_o;
    logic                      wb_we_o;
    logic [DATA_WIDTH/8-1:0]   wb_wstrb_o;
    logic [ADDR_WIDTH-1:0]     wb_addr_o;
    logic [DATA_WIDTH-1:0]     wb_data_o;
    logic [DATA_WIDTH-1:0]     wb_data_i;
    logic                      wb_ack_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  wb_data_i, wb_ack_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_wstrb_o, wb_addr_o, wb_data_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output wb_data_i, wb_ack_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_wstrb_o, wb_addr_o, wb_data_o
    );
endinterface

// File: rtl/obi_wb_bus_arbiter.sv
// Shares one Wishbone bus between OBI fetch and data ports: one transaction
// outstanding, registered responses, optional bus-stall timeout.
module obi_wb_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_core,
    input  logic                  rst_core,
    obi_wb_bus_arbiter_if.slave   bus
);
    localparam int BE_W    = DATA_WIDTH / 8;
    localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            r_state;
    logic                  r_owner;      // 1 = data port owns the bus
    logic                  r_last_data;  // round-robin pointer: last owner was data
    logic                  r_cyc;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BE_W-1:0]       r_wstrb;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_instr_rdata;
    logic [DATA_WIDTH-1:0] r_data_rdata;
    logic                  r_data_err;
    logic                  r_instr_rvalid;
    logic                  r_data_rvalid;
    logic [CNT_W-1:0]      r_cnt;

    logic w_idle;
    logic w_pick_data;
    logic w_gnt_instr;
    logic w_gnt_data;
    logic w_timeout;

    // Data wins when alone, under fixed priority, or when instr owned the bus last.
    assign w_idle      = (r_state == S_IDLE);
    assign w_pick_data = bus.data_req_i &&
                         (!bus.instr_req_i || (ROUND_ROBIN == 0) || !r_last_data);
    assign w_gnt_data  = w_idle && w_pick_data;
    assign w_gnt_instr = w_idle && bus.instr_req_i && !w_pick_data;
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TO_LAST));

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            r_state        <= S_IDLE;
            r_owner        <= 1'b0;
            r_last_data    <= 1'b1;
            r_cyc          <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wstrb        <= '0;
            r_wdata        <= '0;
            r_instr_rdata  <= '0;
            r_data_rdata   <= '0;
            r_data_err     <= 1'b0;
            r_instr_rvalid <= 1'b0;
            r_data_rvalid  <= 1'b0;
            r_cnt          <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_instr || w_gnt_data) begin
                        r_owner <= w_gnt_data;
                        r_addr  <= w_gnt_data ? bus.data_addr_i : bus.instr_addr_i;
                        r_we    <= w_gnt_data && bus.data_we_i;
                        r_wstrb <= (w_gnt_data && bus.data_we_i) ? bus.data_be_i : '0;
                        r_wdata <= w_gnt_data ? bus.data_wdata_i : '0;
                        r_cnt   <= '0;
                        r_cyc   <= 1'b1;
                        r_state <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (bus.wb_ack_i) begin
                        r_cyc   <= 1'b0;
                        r_state <= S_RESP;
                        if (r_owner) begin
                            r_data_rdata  <= bus.wb_data_i;
                            r_data_err    <= 1'b0;
                            r_data_rvalid <= 1'b1;
                        end else begin
                            r_instr_rdata  <= bus.wb_data_i;
                            r_instr_rvalid <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        // Abort the stalled access; only the data port can report an error.
                        r_cyc   <= 1'b0;
                        r_state <= S_RESP;
                        if (r_owner) begin
                            r_data_rdata  <= '0;
                            r_data_err    <= 1'b1;
                            r_data_rvalid <= 1'b1;
                        end else begin
                            r_instr_rdata  <= '0;
                            r_instr_rvalid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_instr_rvalid <= 1'b0;
                    r_data_rvalid  <= 1'b0;
                    r_last_data    <= r_owner;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_gnt_o    = w_gnt_instr;
    assign bus.data_gnt_o     = w_gnt_data;
    assign bus.instr_rvalid_o = r_instr_rvalid;
    assign bus.instr_rdata_o  = r_instr_rdata;
    assign bus.data_rvalid_o  = r_data_rvalid;
    assign bus.data_rdata_o   = r_data_rdata;
    assign bus.data_err_o     = r_data_err;
    assign bus.wb_cyc_o       = r_cyc;
    assign bus.wb_stb_o       = r_cyc;
    assign bus.wb_we_o        = r_we;
    assign bus.wb_wstrb_o     = r_wstrb;
    assign bus.wb_addr_o      = r_addr;
    assign bus.wb_data_o      = r_wdata;
endmodule

// File: tb/tb_obi_wb_bus_arbiter.sv
// Bench for obi_wb_bus_arbiter: a round-robin/timeout instance (A) and a
// fixed-priority/no-timeout instance (B), each with a Wishbone responder and response scoreboard.
module tb_obi_wb_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic          port;   // 1 = data
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    obi_wb_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
    obi_wb_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

    obi_wb_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(4))
        dut_a (.clk_core(clk), .rst_core(rst), .bus(ifa));
    obi_wb_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(0))
        dut_b (.clk_core(clk), .rst_core(rst), .bus(ifb));

    int   n_total = 0;
    int   n_pass  = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   ack_wait_a = 0;
    int   ack_wait_b = 0;
    bit   ack_en_a   = 1'b1;
    bit   ack_en_b   = 1'b1;
    bit   late_ack_a = 1'b0;
    int   wcnt_a = 0;
    int   wcnt_b = 0;
    exp_t obs_a, exp_a, obs_b, exp_b;

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    function automatic exp_t mk_exp(input logic p, input logic [DW-1:0] d, input logic e);
        exp_t r;
        r.port = p;
        r.data = d;
        r.err  = e;
        return r;
    endfunction

    // Wishbone memory models: ack after ack_wait cycles of cyc
    always @(negedge clk) begin
        if (ifa.wb_cyc_o === 1'b1) begin
            if (ack_en_a && wcnt_a == ack_wait_a) begin
                ifa.wb_ack_i  = 1'b1;
                ifa.wb_data_i = rd_model(ifa.wb_addr_o);
            end else begin
                ifa.wb_ack_i = 1'b0;
            end
            wcnt_a++;
        end else begin
            wcnt_a        = 0;
            ifa.wb_ack_i  = late_ack_a;
            ifa.wb_data_i = 32'hBAD0BAD0;
        end
    end

    always @(negedge clk) begin
        if (ifb.wb_cyc_o === 1'b1) begin
            if (ack_en_b && wcnt_b == ack_wait_b) begin
                ifb.wb_ack_i  = 1'b1;
                ifb.wb_data_i = rd_model(ifb.wb_addr_o);
            end else begin
                ifb.wb_ack_i = 1'b0;
            end
            wcnt_b++;
        end else begin
            wcnt_b        = 0;
            ifb.wb_ack_i  = 1'b0;
            ifb.wb_data_i = 32'hBAD0BAD0;
        end
    end

    // Response scoreboards
    always @(negedge clk) begin
        if (ifa.instr_rvalid_o === 1'b1 || ifa.data_rvalid_o === 1'b1) begin
            obs_a = mk_exp(ifa.data_rvalid_o,
                           ifa.data_rvalid_o ? ifa.data_rdata_o : ifa.instr_rdata_o,
                           ifa.data_rvalid_o ? ifa.data_err_o : 1'b0);
            n_total++;
            if (qa.size() == 0) begin
                $display("FAIL a_unexpected_rvalid: got port=%0d data=%h err=%0d, expected no response",
                         obs_a.port, obs_a.data, obs_a.err);
            end else begin
                exp_a = qa.pop_front();
                if (obs_a !== exp_a || (ifa.instr_rvalid_o && ifa.data_rvalid_o))
                    $display("FAIL a_response: got port=%0d data=%h err=%0d (both=%0d), expected port=%0d data=%h err=%0d",
                             obs_a.port, obs_a.data, obs_a.err, ifa.instr_rvalid_o && ifa.data_rvalid_o,
                             exp_a.port, exp_a.data, exp_a.err);
                else n_pass++;
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.instr_rvalid_o === 1'b1 || ifb.data_rvalid_o === 1'b1) begin
            obs_b = mk_exp(ifb.data_rvalid_o,
                           ifb.data_rvalid_o ? ifb.data_rdata_o : ifb.instr_rdata_o,
                           ifb.data_rvalid_o ? ifb.data_err_o : 1'b0);
            n_total++;
            if (qb.size() == 0) begin
                $display("FAIL b_unexpected_rvalid: got port=%0d data=%h err=%0d, expected no response",
                         obs_b.port, obs_b.data, obs_b.err);
            end else begin
                exp_b = qb.pop_front();
                if (obs_b !== exp_b)
                    $display("FAIL b_response: got port=%0d data=%h err=%0d, expected port=%0d data=%h err=%0d",
                             obs_b.port, obs_b.data, obs_b.err, exp_b.port, exp_b.data, exp_b.err);
                else n_pass++;
            end
        end
    end

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if ({ifa.wb_cyc_o, ifa.wb_stb_o, ifa.wb_we_o, ifa.wb_wstrb_o, ifa.wb_addr_o, ifa.wb_data_o,
             ifa.instr_gnt_o, ifa.data_gnt_o, ifa.instr_rvalid_o, ifa.data_rvalid_o,
             ifa.instr_rdata_o, ifa.data_rdata_o, ifa.data_err_o} !== '0)
            $display("FAIL a_reset_outputs: cyc=%b we=%b wstrb=%h addr=%h rv=%b%b err=%b, expected all zero",
                     ifa.wb_cyc_o, ifa.wb_we_o, ifa.wb_wstrb_o, ifa.wb_addr_o,
                     ifa.instr_rvalid_o, ifa.data_rvalid_o, ifa.data_err_o);
        else n_pass++;
        n_total++;
        if ({ifb.wb_cyc_o, ifb.wb_stb_o, ifb.wb_we_o, ifb.wb_wstrb_o, ifb.wb_addr_o, ifb.wb_data_o,
             ifb.instr_gnt_o, ifb.data_gnt_o, ifb.instr_rvalid_o, ifb.data_rvalid_o,
             ifb.instr_rdata_o, ifb.data_rdata_o, ifb.data_err_o} !== '0)
            $display("FAIL b_reset_outputs: cyc=%b we=%b wstrb=%h addr=%h rv=%b%b err=%b, expected all zero",
                     ifb.wb_cyc_o, ifb.wb_we_o, ifb.wb_wstrb_o, ifb.wb_addr_o,
                     ifb.instr_rvalid_o, ifb.data_rvalid_o, ifb.data_err_o);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch;
        ack_wait_a = 0;
        @(negedge clk);
        ifa.instr_req_i  = 1'b1;
        ifa.instr_addr_i = 32'h100;
        #1;
        n_total++;
        if ({ifa.instr_gnt_o, ifa.data_gnt_o} !== 2'b10)
            $display("FAIL fetch_gnt_t0: got %b, expected 10", {ifa.instr_gnt_o, ifa.data_gnt_o});
        else n_pass++;
        qa.push_back(mk_exp(1'b0, 32'hDEADBEEF, 1'b0));
        @(negedge clk); #1;
        n_total++;
        if ({ifa.wb_cyc_o, ifa.wb_stb_o, ifa.wb_we_o, ifa.wb_wstrb_o, ifa.wb_addr_o, ifa.instr_gnt_o}
            !== {1'b1, 1'b1, 1'b0, 4'h0, 32'h100, 1'b0})
            $display("FAIL fetch_bus_t1: cyc=%b stb=%b we=%b wstrb=%h addr=%h gnt=%b, expected 1 1 0 0 00000100 0",
                     ifa.wb_cyc_o, ifa.wb_stb_o, ifa.wb_we_o, ifa.wb_wstrb_o, ifa.wb_addr_o, ifa.instr_gnt_o);
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if ({ifa.wb_cyc_o, ifa.instr_rvalid_o, ifa.instr_gnt_o} !== 3'b010)
            $display("FAIL fetch_resp_t2: cyc/rvalid/gnt=%b, expected 010",
                     {ifa.wb_cyc_o, ifa.instr_rvalid_o, ifa.instr_gnt_o});
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if ({ifa.instr_gnt_o, ifa.instr_rvalid_o} !== 2'b10)
            $display("FAIL fetch_regnt_t3: gnt/rvalid=%b, expected 10", {ifa.instr_gnt_o, ifa.instr_rvalid_o});
        else n_pass++;
        ifa.instr_req_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store;
        ack_wait_a = 3;
        @(negedge clk);
        ifa.data_req_i   = 1'b1;
        ifa.data_we_i    = 1'b1;
        ifa.data_be_i    = 4'b0011;
        ifa.data_addr_i  = 32'h2004;
        ifa.data_wdata_i = 32'h12345678;
        #1;
        n_total++;
        if ({ifa.instr_gnt_o, ifa.data_gnt_o} !== 2'b01)
            $display("FAIL store_gnt: got %b, expected 01", {ifa.instr_gnt_o, ifa.data_gnt_o});
        else n_pass++;
        qa.push_back(mk_exp(1'b1, rd_model(32'h2004), 1'b0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (i == 0) begin
                ifa.data_req_i   = 1'b0;
                ifa.data_we_i    = 1'b0;
                ifa.data_be_i    = 4'hC;
                ifa.data_addr_i  = 32'hFFFF0000;
                ifa.data_wdata_i = 32'h0;
            end
            n_total++;
            if ({ifa.wb_cyc_o, ifa.wb_stb_o, ifa.wb_we_o, ifa.wb_wstrb_o, ifa.wb_addr_o, ifa.wb_data_o, ifa.data_rvalid_o}
                !== {1'b1, 1'b1, 1'b1, 4'b0011, 32'h2004, 32'h12345678, 1'b0})
                $display("FAIL store_bus_cycle%0d: cyc=%b we=%b wstrb=%b addr=%h wdata=%h rvalid=%b, expected 1 1 0011 00002004 12345678 0",
                         i, ifa.wb_cyc_o, ifa.wb_we_o, ifa.wb_wstrb_o, ifa.wb_addr_o, ifa.wb_data_o, ifa.data_rvalid_o);
            else n_pass++;
        end
        @(negedge clk); #1;
        n_total++;
        if ({ifa.wb_cyc_o, ifa.data_rvalid_o, ifa.data_err_o} !== 3'b010)
            $display("FAIL store_resp: cyc/rvalid/err=%b, expected 010",
                     {ifa.wb_cyc_o, ifa.data_rvalid_o, ifa.data_err_o});
        else n_pass++;
        n_total++;
        if (ifa.instr_rdata_o !== 32'hDEADBEEF)
            $display("FAIL instr_rdata_hold: got %h, expected deadbeef", ifa.instr_rdata_o);
        else n_pass++;
        ack_wait_a = 0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        ack_en_a = 1'b0;
        @(negedge clk);
        ifa.data_req_i  = 1'b1;
        ifa.data_we_i   = 1'b0;
        ifa.data_be_i   = 4'hF;
        ifa.data_addr_i = 32'h500;
        #1;
        n_total++;
        if ({ifa.instr_gnt_o, ifa.data_gnt_o} !== 2'b01)
            $display("FAIL timeout_gnt: got %b, expected 01", {ifa.instr_gnt_o, ifa.data_gnt_o});
        else n_pass++;
        qa.push_back(mk_exp(1'b1, 32'h0, 1'b1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (i == 0) ifa.data_req_i = 1'b0;
            if (i == 3) late_ack_a = 1'b1;
            n_total++;
            if ({ifa.wb_cyc_o, ifa.wb_we_o, ifa.wb_wstrb_o, ifa.wb_addr_o, ifa.data_rvalid_o}
                !== {1'b1, 1'b0, 4'h0, 32'h500, 1'b0})
                $display("FAIL timeout_bus_cycle%0d: cyc=%b we=%b wstrb=%h addr=%h rvalid=%b, expected 1 0 0 00000500 0",
                         i, ifa.wb_cyc_o, ifa.wb_we_o, ifa.wb_wstrb_o, ifa.wb_addr_o, ifa.data_rvalid_o);
            else n_pass++;
        end
        @(negedge clk); #1;
        n_total++;
        if ({ifa.wb_cyc_o, ifa.data_rvalid_o, ifa.data_err_o} !== 3'b011)
            $display("FAIL timeout_resp: cyc/rvalid/err=%b, expected 011",
                     {ifa.wb_cyc_o, ifa.data_rvalid_o, ifa.data_err_o});
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_total++;
            if ({ifa.wb_cyc_o, ifa.data_rvalid_o, ifa.instr_rvalid_o, ifa.data_err_o, ifa.data_rdata_o}
                !== {1'b0, 1'b0, 1'b0, 1'b1, 32'h0})
                $display("FAIL late_ack_ignored%0d: cyc=%b rvalid=%b%b err=%b rdata=%h, expected 0 00 1 00000000",
                         i, ifa.wb_cyc_o, ifa.instr_rvalid_o, ifa.data_rvalid_o, ifa.data_err_o, ifa.data_rdata_o);
            else n_pass++;
        end
        late_ack_a = 1'b0;
        ack_en_a   = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        int ng;
        bit exp_d;
        ng = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 0) begin
                ifa.instr_req_i  = 1'b1;
                ifa.instr_addr_i = 32'h300;
                ifa.data_req_i   = 1'b1;
                ifa.data_we_i    = 1'b0;
                ifa.data_be_i    = 4'hF;
                ifa.data_addr_i  = 32'h400;
            end
            #1;
            if (ifa.instr_gnt_o || ifa.data_gnt_o) begin
                exp_d = ng[0];
                n_total++;
                if ({ifa.instr_gnt_o, ifa.data_gnt_o, ifa.wb_cyc_o} !== {~exp_d, exp_d, 1'b0})
                    $display("FAIL rr_grant%0d: gnt_i/gnt_d/cyc=%b, expected %b",
                             ng, {ifa.instr_gnt_o, ifa.data_gnt_o, ifa.wb_cyc_o}, {~exp_d, exp_d, 1'b0});
                else n_pass++;
                qa.push_back(mk_exp(exp_d, rd_model(exp_d ? 32'h400 : 32'h300), 1'b0));
                ng++;
            end
        end
        @(negedge clk);
        ifa.instr_req_i = 1'b0;
        ifa.data_req_i  = 1'b0;
        n_total++;
        if (ng !== 5) $display("FAIL rr_grant_count: got %0d, expected 5", ng);
        else n_pass++;
    endtask

    task automatic test_fixed_priority;
        int ng;
        ng = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin
                ifb.instr_req_i  = 1'b1;
                ifb.instr_addr_i = 32'h300;
                ifb.data_req_i   = 1'b1;
                ifb.data_we_i    = 1'b0;
                ifb.data_be_i    = 4'hF;
                ifb.data_addr_i  = 32'h400;
            end
            #1;
            if (ifb.instr_gnt_o || ifb.data_gnt_o) begin
                n_total++;
                if ({ifb.instr_gnt_o, ifb.data_gnt_o} !== 2'b01)
                    $display("FAIL fixed_grant%0d: gnt_i/gnt_d=%b, expected 01", ng, {ifb.instr_gnt_o, ifb.data_gnt_o});
                else n_pass++;
                qb.push_back(mk_exp(1'b1, rd_model(32'h400), 1'b0));
                ng++;
            end
        end
        @(negedge clk);
        ifb.instr_req_i = 1'b0;
        ifb.data_req_i  = 1'b0;
        n_total++;
        if (ng !== 4) $display("FAIL fixed_grant_count: got %0d, expected 4", ng);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        ack_en_a = 1'b0;
        @(negedge clk);
        ifa.data_req_i   = 1'b1;
        ifa.data_we_i    = 1'b1;
        ifa.data_be_i    = 4'hF;
        ifa.data_addr_i  = 32'h600;
        ifa.data_wdata_i = 32'hCAFEF00D;
        #1;
        n_total++;
        if ({ifa.instr_gnt_o, ifa.data_gnt_o} !== 2'b01)
            $display("FAIL rstmid_gnt: got %b, expected 01", {ifa.instr_gnt_o, ifa.data_gnt_o});
        else n_pass++;
        qa.push_back(mk_exp(1'b1, rd_model(32'h600), 1'b0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            ifa.data_req_i = 1'b0;
            n_total++;
            if (ifa.wb_cyc_o !== 1'b1) $display("FAIL rstmid_cyc_before%0d: got %b, expected 1", i, ifa.wb_cyc_o);
            else n_pass++;
        end
        rst = 1'b1;
        #1;
        qa.delete();
        n_total++;
        if ({ifa.wb_cyc_o, ifa.wb_stb_o} !== 2'b00)
            $display("FAIL rstmid_cyc_drop: cyc/stb=%b, expected 00", {ifa.wb_cyc_o, ifa.wb_stb_o});
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_total++;
            if ({ifa.wb_cyc_o, ifa.instr_rvalid_o, ifa.data_rvalid_o} !== 3'b000)
                $display("FAIL rstmid_quiet%0d: cyc/rvalid=%b, expected 000",
                         i, {ifa.wb_cyc_o, ifa.instr_rvalid_o, ifa.data_rvalid_o});
            else n_pass++;
        end
        @(negedge clk);
        rst              = 1'b0;
        ack_en_a         = 1'b1;
        ifa.instr_req_i  = 1'b1;
        ifa.instr_addr_i = 32'h100;
        ifa.data_req_i   = 1'b1;
        ifa.data_we_i    = 1'b0;
        ifa.data_addr_i  = 32'h700;
        #1;
        n_total++;
        if ({ifa.instr_gnt_o, ifa.data_gnt_o} !== 2'b10)
            $display("FAIL post_reset_rr_gnt: got %b, expected 10", {ifa.instr_gnt_o, ifa.data_gnt_o});
        else n_pass++;
        qa.push_back(mk_exp(1'b0, 32'hDEADBEEF, 1'b0));
        @(negedge clk); #1;
        ifa.instr_req_i = 1'b0;
        ifa.data_req_i  = 1'b0;
        n_total++;
        if ({ifa.wb_cyc_o, ifa.wb_addr_o} !== {1'b1, 32'h100})
            $display("FAIL post_reset_bus: cyc=%b addr=%h, expected 1 00000100", ifa.wb_cyc_o, ifa.wb_addr_o);
        else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (ifa.instr_rvalid_o !== 1'b1)
            $display("FAIL post_reset_rvalid: got %b, expected 1", ifa.instr_rvalid_o);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifa.instr_req_i = 1'b0; ifa.instr_addr_i = '0; ifa.data_req_i = 1'b0; ifa.data_we_i = 1'b0;
        ifa.data_be_i = '0; ifa.data_addr_i = '0; ifa.data_wdata_i = '0;
        ifb.instr_req_i = 1'b0; ifb.instr_addr_i = '0; ifb.data_req_i = 1'b0; ifb.data_we_i = 1'b0;
        ifb.data_be_i = '0; ifb.data_addr_i = '0; ifb.data_wdata_i = '0;
        test_reset();
        test_single_fetch();
        test_store();
        test_timeout();
        test_round_robin();
        test_fixed_priority();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_total++;
        if (qa.size() != 0 || qb.size() != 0)
            $display("FAIL scoreboard_drain: pending a=%0d b=%0d, expected 0 0", qa.size(), qb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/obi_wb_bus_arbiter.md
Name: obi_wb_bus_arbiter

Overview:
- Shares one Wishbone-style memory bus between a core's two OBI-style request/grant/rvalid ports: instruction fetch and data load/store.
- Sits between the core and the Controller bus in processorci_top.
- Replaces the ad-hoc ack/data re-registering in processorci_top for single-memory configurations.
- Arbitrates, holds one transaction outstanding at a time, registers responses and bounds bus stalls with a timeout.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; byte-enable width = DATA_WIDTH/8
ROUND_ROBIN, 1, 1 = alternate on contention; 0 = data port always wins
TIMEOUT_CYCLES, 255, bus cycles without ack before abort; 0 disables the timeout

Ports:
clk_core  in  1  core clock, all logic on rising edge
rst_core  in  1  asynchronous reset, active-high
instr_req_i  in  1  instruction fetch request
instr_addr_i  in  ADDR_WIDTH  fetch address
instr_gnt_o  out  1  fetch accepted (combinational, IDLE only)
instr_rvalid_o  out  1  fetch response strobe, one cycle
instr_rdata_o  out  DATA_WIDTH  fetched word, valid with rvalid
data_req_i  in  1  data request
data_we_i  in  1  1 = store
data_be_i  in  DATA_WIDTH/8  store byte enables
data_addr_i  in  ADDR_WIDTH  data address
data_wdata_i  in  DATA_WIDTH  store data
data_gnt_o  out  1  data accepted (combinational, IDLE only)
data_rvalid_o  out  1  data response strobe (loads and stores), one cycle
data_rdata_o  out  DATA_WIDTH  load data, valid with rvalid
data_err_o  out  1  timeout error, valid with data_rvalid_o
wb_cyc_o  out  1  bus cycle active
wb_stb_o  out  1  equals wb_cyc_o
wb_we_o  out  1  write enable
wb_wstrb_o  out  DATA_WIDTH/8  byte strobes
wb_addr_o  out  ADDR_WIDTH  bus address
wb_data_o  out  DATA_WIDTH  write data
wb_data_i  in  DATA_WIDTH  read data
wb_ack_i  in  1  transaction acknowledge

Behaviour:
- Reset (async, rst_core=1):
  - state=IDLE; all registered outputs 0; timeout counter 0.
  - RR pointer = "last owner data", so instr wins first contention.
  - Reset mid-transaction drops wb_cyc_o immediately; no rvalid for the aborted access.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - Winner selection: only instr_req_i -> instr; only data_req_i -> data.
  - Both requesting: ROUND_ROBIN=1 -> the port that did not own the last transaction; ROUND_ROBIN=0 -> data.
  - The winner's gnt_o is asserted combinationally in that cycle.
  - On that edge: latch owner, addr, we (instr: 0), wstrb (store: data_be_i; load and fetch: 0), wdata (instr: 0). Next state BUS.
  - No request: stay in IDLE.
- BUS:
  - wb_cyc_o=wb_stb_o=1; addr/we/wstrb/data driven from the latched registers, stable until ack.
  - On wb_ack_i: capture wb_data_i into the owner's rdata register, clear err, deassert cyc on the same edge, go to RESP.
  - Else, if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1: deassert cyc, rdata=0, err=1 (data owner only; instr has no err), go to RESP.
  - Ack and timeout in the same cycle: ack wins.
  - Counter clears on entry to BUS.
- RESP:
  - Owner's rvalid=1 for exactly one cycle; update RR pointer; go to IDLE.
  - No grants issued in RESP.
- Both gnt outputs are 0 outside IDLE.
- wb_ack_i outside BUS is ignored.
- rdata registers hold their value until the next response to the same port.
- Timing: gnt at T0, cyc at T1; ack at Tk (k≥1) gives rvalid at Tk+1. With zero-wait ack, back-to-back throughput is one access per 3 cycles.

Test Plan:
- Single fetch: instr_req, addr 0x100; ack in the first bus cycle with data 0xDEADBEEF -> gnt T0, cyc T1 with we=0/wstrb=0, instr_rvalid T2 with rdata 0xDEADBEEF, gnt again T3.
- Store: data_we=1, be=4'b0011, addr 0x2004, wdata 0x12345678; ack after 3 wait cycles -> wb_we=1, wstrb=0011, fields stable all 4 bus cycles, one data_rvalid with err=0.
- Contention with ROUND_ROBIN=1, both requesting continuously -> grant order instr, data, instr, data; no overlap of cyc between transactions.
- ROUND_ROBIN=0, both requesting continuously -> data granted every time, instr never granted.
- Timeout with TIMEOUT_CYCLES=4, no ack -> cyc high exactly 4 cycles, then data_rvalid with err=1, rdata=0; a late ack is ignored.
- Reset asserted while cyc=1 -> cyc 0 immediately, no rvalid; first request after release is granted normally.
